multicycle_main_ctrl: RTL and testbench
=======================================

Name: multicycle_main_ctrl

Overview:
- Multi-cycle MIPS main control FSM; the producer side of the ALU_OP/Funct interface into the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables, mux selects and the 2-bit ALU_OP (00 add, 01 beq subtract, 10 R-type use Funct).
- Stalls on a memory ready handshake.

Parameters:
ENABLE_ADDI, 1, 1 = addi (opcode 001000) supported; 0 = addi treated as illegal

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-high reset
Op  in  6  opcode field from instruction register; stable from DECODE onward
Mem_Ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU Zero (beq)
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  register write data: 0 ALUOut, 1 MDR
RegDst  out  1  destination register: 0 rt, 1 rd
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 PC, 1 register A
ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
ALU_OP  out  2  to ALU control decoder
Instr_Done  out  1  one-cycle pulse in an instruction's final cycle
Illegal_Op  out  1  one-cycle pulse on an unsupported opcode
State  out  4  current state code, for debug

Behaviour:
- Single clock domain: clk_i; rst_i asynchronous, active-high.
- State register 4 bits, next-state logic combinational. Outputs decode from state, qualified by Mem_Ready where noted.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12. Codes 13-15 go to IDLE.
- Reset:
  - rst_i asserted moves State to IDLE immediately, regardless of clock.
  - Every output is 0 while in IDLE, including ALU_OP=00 and State=0.
  - Reset mid-instruction abandons it; no partial writes are issued after reset assertion.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH: holds while Mem_Ready=0; goes to DECODE when Mem_Ready=1.
  - DECODE dispatches on Op:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 with ENABLE_ADDI=1 -> ADDI_EXEC
    - any other opcode -> FETCH, with Illegal_Op=1 for that DECODE cycle
  - MEM_ADDR -> MEM_RD if Op=100011, otherwise MEM_WR.
  - MEM_RD: holds until Mem_Ready, then MEM_WB. MEM_WB -> FETCH.
  - MEM_WR: holds until Mem_Ready, then FETCH.
  - R_EXEC -> R_WB -> FETCH.
  - BRANCH -> FETCH. JUMP -> FETCH.
  - ADDI_EXEC -> ADDI_WB -> FETCH.
- Asserted outputs per state (any output not listed is 0):
  - FETCH: MemRead=1, ALUSrcB=01, ALU_OP=00; IRWrite=PCWrite=Mem_Ready.
  - DECODE: ALUSrcB=11, ALU_OP=00.
  - MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_OP=00.
  - MEM_RD: MemRead=1, IorD=1, held for the whole wait.
  - MEM_WR: MemWrite=1, IorD=1, held for the whole wait; Instr_Done=Mem_Ready.
  - MEM_WB: RegWrite=1, MemtoReg=1, Instr_Done=1.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_OP=10.
  - R_WB: RegWrite=1, RegDst=1, Instr_Done=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_OP=01, PCWriteCond=1, PCSource=01, Instr_Done=1.
  - JUMP: PCWrite=1, PCSource=10, Instr_Done=1.
  - ADDI_WB: RegWrite=1, Instr_Done=1.
- Invariants:
  - IRWrite and PCWrite in FETCH never assert without Mem_Ready.
  - MemRead and MemWrite are never both 1.
  - RegWrite is never 1 in the same cycle as MemWrite.
- Cycle counts with zero memory wait, FETCH through the final state inclusive: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memory wait cycle adds 1.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALU_OP encodings: ALUOP_ADD 00, ALUOP_SUB 01, ALUOP_FUNCT 10
  - state code constants
- These constants are shared with the ALU control decoder and the datapath.
- A single module is sufficient; no sub-module.

Test Plan:
- Reset: assert rst_i between clock edges mid-MEM_RD -> State=0 and all outputs 0 immediately; after release, FETCH on the next edge.
- R-type add: Op=000000, Mem_Ready=1 -> states 1,2,7,8,1; ALU_OP=10 in R_EXEC; RegWrite=RegDst=1 and Instr_Done=1 in R_WB.
- lw with 3 wait cycles in MEM_RD: Op=100011 -> MemRead=IorD=1 held 4 cycles; MEM_WB has RegWrite=MemtoReg=1; 8 cycles total from FETCH.
- sw with FETCH wait of 2: IRWrite/PCWrite stay 0 during the 2 wait cycles and are 1 only in the ready cycle; MemWrite=1 in MEM_WR, never with RegWrite.
- beq then j: beq gives ALU_OP=01, PCWriteCond=1, PCSource=01; j gives PCWrite=1, PCSource=10; each takes 3 cycles.
- Illegal/parameter case: Op=111111 -> Illegal_Op pulses in DECODE, then FETCH. With ENABLE_ADDI=0, Op=001000 behaves the same.

Source files
------------

// File: rtl/multicycle_main_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control, the ALU control
// decoder and the datapath: opcodes, ALU_OP encodings, mux selects, state codes.
package multicycle_main_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU_OP encodings seen by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State codes (also exported on the State debug port)
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12
  } state_e;

  // True when the opcode is one this controller executes
  function automatic logic op_supported(input logic [5:0] op, input logic en_addi);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      OP_ADDI:                              ok = en_addi;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle MIPS main control FSM. Steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables, mux
// selects and ALU_OP. Memory accesses stall on Mem_Ready.
//
// Handshake: a memory access (FETCH, MEM_RD, MEM_WR) holds its request
// asserted until the cycle in which Mem_Ready=1; that cycle completes the
// access and the FSM leaves the state on the following clock edge.
module multicycle_main_ctrl
  import multicycle_main_ctrl_pkg::*;
#(
  parameter logic ENABLE_ADDI = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op,
  input  logic       Mem_Ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_OP,
  output logic       Instr_Done,
  output logic       Illegal_Op,
  output logic [3:0] State
);

  state_e r_state;
  state_e w_next;
  logic   w_supported;

  assign w_supported = op_supported(Op, ENABLE_ADDI);
  assign State       = r_state;

  // State register; reset drops straight to IDLE, abandoning any instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: opcode dispatch in DECODE, stalls on Mem_Ready in memory states
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:      w_next = ST_FETCH;
      ST_FETCH:     w_next = Mem_Ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Op)
          OP_RTYPE:      w_next = ST_R_EXEC;
          OP_LW, OP_SW:  w_next = ST_MEM_ADDR;
          OP_BEQ:        w_next = ST_BRANCH;
          OP_J:          w_next = ST_JUMP;
          OP_ADDI:       w_next = ENABLE_ADDI ? ST_ADDI_EXEC : ST_FETCH;
          default:       w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  w_next = (Op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:    w_next = Mem_Ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WR:    w_next = Mem_Ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
      ST_ADDI_EXEC: w_next = ST_ADDI_WB;
      ST_ADDI_WB:   w_next = ST_FETCH;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Output decode from state; FETCH write enables and MEM_WR completion gated by Mem_Ready
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALU_OP      = ALUOP_ADD;
    Instr_Done  = 1'b0;
    Illegal_Op  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = Mem_Ready;
        PCWrite = Mem_Ready;
      end
      ST_DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        Illegal_Op = ~w_supported;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        Instr_Done = Mem_Ready;
      end
      ST_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        Instr_Done = 1'b1;
      end
      ST_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALU_OP  = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        Instr_Done = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_OP      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        Instr_Done  = 1'b1;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        Instr_Done = 1'b1;
      end
      ST_ADDI_WB: begin
        RegWrite   = 1'b1;
        Instr_Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: per-instruction expected cycle traces built
// from the instruction behaviour table, plus a second instance without addi.
module tb_multicycle_main_ctrl;
  import multicycle_main_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0] op;
  logic       mr;
  logic [5:0] op1;
  logic       mr1;

  // DUT0 outputs (ENABLE_ADDI=1)
  logic       d0_pcw, d0_pcwc, d0_iord, d0_mrd, d0_mwr, d0_irw, d0_m2r, d0_rdst, d0_rw;
  logic       d0_srca, d0_done, d0_ill;
  logic [1:0] d0_pcsrc, d0_srcb, d0_aluop;
  logic [3:0] d0_state;
  // DUT1 outputs (ENABLE_ADDI=0)
  logic       d1_pcw, d1_pcwc, d1_iord, d1_mrd, d1_mwr, d1_irw, d1_m2r, d1_rdst, d1_rw;
  logic       d1_srca, d1_done, d1_ill;
  logic [1:0] d1_pcsrc, d1_srcb, d1_aluop;
  logic [3:0] d1_state;

  multicycle_main_ctrl #(.ENABLE_ADDI(1'b1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .Op(op), .Mem_Ready(mr),
    .PCWrite(d0_pcw), .PCWriteCond(d0_pcwc), .PCSource(d0_pcsrc), .IorD(d0_iord),
    .MemRead(d0_mrd), .MemWrite(d0_mwr), .IRWrite(d0_irw), .MemtoReg(d0_m2r),
    .RegDst(d0_rdst), .RegWrite(d0_rw), .ALUSrcA(d0_srca), .ALUSrcB(d0_srcb),
    .ALU_OP(d0_aluop), .Instr_Done(d0_done), .Illegal_Op(d0_ill), .State(d0_state)
  );

  multicycle_main_ctrl #(.ENABLE_ADDI(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .Op(op1), .Mem_Ready(mr1),
    .PCWrite(d1_pcw), .PCWriteCond(d1_pcwc), .PCSource(d1_pcsrc), .IorD(d1_iord),
    .MemRead(d1_mrd), .MemWrite(d1_mwr), .IRWrite(d1_irw), .MemtoReg(d1_m2r),
    .RegDst(d1_rdst), .RegWrite(d1_rw), .ALUSrcA(d1_srca), .ALUSrcB(d1_srcb),
    .ALU_OP(d1_aluop), .Instr_Done(d1_done), .Illegal_Op(d1_ill), .State(d1_state)
  );

  // Packed view of all DUT0 outputs
  localparam int B_PCW = 21, B_PCWC = 20, B_PCSRC = 18, B_IORD = 17, B_MRD = 16;
  localparam int B_MWR = 15, B_IRW = 14, B_M2R = 13, B_RDST = 12, B_RW = 11;
  localparam int B_SRCA = 10, B_SRCB = 8, B_ALUOP = 6, B_DONE = 5, B_ILL = 4;

  logic [21:0] obs0;
  assign obs0 = {d0_pcw, d0_pcwc, d0_pcsrc, d0_iord, d0_mrd, d0_mwr, d0_irw, d0_m2r,
                 d0_rdst, d0_rw, d0_srca, d0_srcb, d0_aluop, d0_done, d0_ill, d0_state};
  logic [21:0] obs1;
  assign obs1 = {d1_pcw, d1_pcwc, d1_pcsrc, d1_iord, d1_mrd, d1_mwr, d1_irw, d1_m2r,
                 d1_rdst, d1_rw, d1_srca, d1_srcb, d1_aluop, d1_done, d1_ill, d1_state};

  // ---------------- scoreboard state ----------------
  logic [21:0] exp_q[$];
  logic        mr_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_len  = 0;
  int e1       = 0;  // expected DUT1 state: it loops FETCH / DECODE(illegal addi)

  function automatic logic legal1(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b000010) || (o == 6'b001000);
  endfunction

  // Instruction length with no memory wait, FETCH to final cycle
  function automatic int base_len(input logic [5:0] o);
    case (o)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b001000: return 4;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [21:0] st(input int s);
    logic [21:0] v;
    v = '0;
    v[3:0] = s[3:0];
    return v;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle outputs for one instruction (fw fetch waits, mw memory waits)
  task automatic build(input logic [5:0] o, input int fw, input int mw);
    logic [21:0] v;
    for (int i = 0; i <= fw; i++) begin
      v = st(1); v[B_MRD] = 1'b1; v[B_SRCB +: 2] = 2'b01;
      if (i == fw) begin v[B_IRW] = 1'b1; v[B_PCW] = 1'b1; end
      exp_q.push_back(v); mr_q.push_back(i == fw);
    end
    v = st(2); v[B_SRCB +: 2] = 2'b11; v[B_ILL] = !legal1(o);
    exp_q.push_back(v); mr_q.push_back(rnd_bit());
    case (o)
      6'b000000: begin
        v = st(7); v[B_SRCA] = 1'b1; v[B_ALUOP +: 2] = 2'b10;
        exp_q.push_back(v); mr_q.push_back(rnd_bit());
        v = st(8); v[B_RW] = 1'b1; v[B_RDST] = 1'b1; v[B_DONE] = 1'b1;
        exp_q.push_back(v); mr_q.push_back(rnd_bit());
      end
      6'b100011, 6'b101011, 6'b001000: begin
        v = (o == 6'b001000) ? st(11) : st(3);
        v[B_SRCA] = 1'b1; v[B_SRCB +: 2] = 2'b10;
        exp_q.push_back(v); mr_q.push_back(rnd_bit());
        if (o == 6'b001000) begin
          v = st(12); v[B_RW] = 1'b1; v[B_DONE] = 1'b1;
          exp_q.push_back(v); mr_q.push_back(rnd_bit());
        end else if (o == 6'b100011) begin
          for (int i = 0; i <= mw; i++) begin
            v = st(4); v[B_MRD] = 1'b1; v[B_IORD] = 1'b1;
            exp_q.push_back(v); mr_q.push_back(i == mw);
          end
          v = st(5); v[B_RW] = 1'b1; v[B_M2R] = 1'b1; v[B_DONE] = 1'b1;
          exp_q.push_back(v); mr_q.push_back(rnd_bit());
        end else begin
          for (int i = 0; i <= mw; i++) begin
            v = st(6); v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_DONE] = (i == mw);
            exp_q.push_back(v); mr_q.push_back(i == mw);
          end
        end
      end
      6'b000100: begin
        v = st(9); v[B_SRCA] = 1'b1; v[B_ALUOP +: 2] = 2'b01; v[B_PCWC] = 1'b1;
        v[B_PCSRC +: 2] = 2'b01; v[B_DONE] = 1'b1;
        exp_q.push_back(v); mr_q.push_back(rnd_bit());
      end
      6'b000010: begin
        v = st(10); v[B_PCW] = 1'b1; v[B_PCSRC +: 2] = 2'b10; v[B_DONE] = 1'b1;
        exp_q.push_back(v); mr_q.push_back(rnd_bit());
      end
      default: ;
    endcase
  endtask

  // Check DUT1 against its FETCH/DECODE loop
  task automatic check_dut1();
    logic [21:0] v;
    v = st(e1);
    if (e1 == 1) begin v[B_MRD] = 1'b1; v[B_SRCB +: 2] = 2'b01; v[B_IRW] = 1'b1; v[B_PCW] = 1'b1; end
    if (e1 == 2) begin v[B_SRCB +: 2] = 2'b11; v[B_ILL] = 1'b1; end
    n_checks++;
    assert (obs1 === v) begin n_pass++; end
    else $error("FAIL noaddi_dut obs=%h exp=%h", obs1, v);
  endtask

  // One clock cycle: drive Mem_Ready, sample mid-low-phase, compare, advance
  task automatic step(input logic [21:0] e, input logic m);
    mr = m;
    #1;
    n_checks++;
    assert (obs0 === e) begin n_pass++; end
    else $error("FAIL trace op=%b obs=%h exp=%h", op, obs0, e);
    n_checks++;
    assert (!(d0_mrd && d0_mwr) && !(d0_rw && d0_mwr)) begin n_pass++; end
    else $error("FAIL mem_excl rd=%b wr=%b rw=%b exp no overlap", d0_mrd, d0_mwr, d0_rw);
    if (d0_state == 4'd1 && !mr) begin
      n_checks++;
      assert (!d0_irw && !d0_pcw) begin n_pass++; end
      else $error("FAIL fetch_wait irw=%b pcw=%b exp 0", d0_irw, d0_pcw);
    end
    cyc++;
    if (d0_done) begin
      n_checks++;
      assert (cyc == exp_len) begin n_pass++; end
      else $error("FAIL cycle_count obs=%0d exp=%0d", cyc, exp_len);
    end
    check_dut1();
    @(posedge clk);
    e1 = rst ? 0 : ((e1 == 1) ? 2 : 1);
    @(negedge clk);
  endtask

  // Drive one instruction; max_cyc>0 stops early (for the reset test)
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input int max_cyc);
    int n;
    exp_q.delete(); mr_q.delete();
    build(o, fw, mw);
    exp_len = base_len(o) + fw + (((o == 6'b100011) || (o == 6'b101011)) ? mw : 0);
    cyc = 0;
    op = o;
    n = 0;
    while (exp_q.size() > 0 && (max_cyc == 0 || n < max_cyc)) begin
      step(exp_q.pop_front(), mr_q.pop_front());
      n++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    assert (obs0 === 22'd0) begin n_pass++; end
    else $error("FAIL %s obs=%h exp=0", tag, obs0);
    check_dut1();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] o;
    int k;
    rst = 1'b1; op = 6'd0; mr = 1'b0; op1 = 6'b001000; mr1 = 1'b1; e1 = 0;
    repeat (2) @(negedge clk);
    #1 check_reset_state("reset_idle");
    rst = 1'b0;
    check_reset_state("release_idle");
    @(posedge clk); e1 = 1;
    @(negedge clk);

    run_instr(6'b000000, 0, 0, 0);  // R-type
    run_instr(6'b100011, 0, 3, 0);  // lw, 3 memory waits
    run_instr(6'b101011, 2, 0, 0);  // sw, 2 fetch waits
    run_instr(6'b000100, 0, 0, 0);  // beq
    run_instr(6'b000010, 0, 0, 0);  // j
    run_instr(6'b111111, 0, 0, 0);  // illegal
    run_instr(6'b001000, 1, 0, 0);  // addi

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: o = 6'b000000;
        1: o = 6'b100011;
        2: o = 6'b101011;
        3: o = 6'b000100;
        4: o = 6'b000010;
        5: o = 6'b001000;
        default: begin
          o = 6'($urandom_range(0, 63));
          while (legal1(o)) o = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end

    // Reset asserted between edges while lw waits in MEM_RD
    run_instr(6'b100011, 0, 3, 4);
    mr = 1'b0;
    #1 rst = 1'b1;
    e1 = 0;
    #1 check_reset_state("async_reset");
    @(posedge clk);
    @(negedge clk);
    #1 check_reset_state("reset_held");
    rst = 1'b0;
    check_reset_state("reset_release");
    @(posedge clk); e1 = 1;
    @(negedge clk);
    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b100011, 1, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
